// File: rtl/memory_access_unit_pkg.sv
// memory_access_unit_pkg
// Shared definitions for the CPU memory access unit: the MIPS opcodes it
// executes, the FSM state encoding and small opcode-decoding helpers.
package memory_access_unit_pkg;

  localparam logic [5:0] OPCODE_LB  = 6'h20;
  localparam logic [5:0] OPCODE_LW  = 6'h23;
  localparam logic [5:0] OPCODE_LBU = 6'h24;
  localparam logic [5:0] OPCODE_SB  = 6'h28;
  localparam logic [5:0] OPCODE_SW  = 6'h2B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } mau_state_e;

  function automatic logic op_is_store(input logic [5:0] op);
    return (op == OPCODE_SW) || (op == OPCODE_SB);
  endfunction

  function automatic logic op_is_word(input logic [5:0] op);
    return (op == OPCODE_LW) || (op == OPCODE_SW);
  endfunction

  function automatic logic op_is_valid(input logic [5:0] op);
    return (op == OPCODE_LW) || (op == OPCODE_SW) || (op == OPCODE_LB) ||
           (op == OPCODE_LBU) || (op == OPCODE_SB);
  endfunction

  // Unknown opcodes and misaligned word accesses never reach the bus.
  function automatic logic op_fault(input logic [5:0] op, input logic [1:0] ea_lo);
    return !op_is_valid(op) || (op_is_word(op) && (ea_lo != 2'b00));
  endfunction

endpackage

// File: rtl/memory_access_unit_load_byte_extract.sv
// load_byte_extract
// Purely combinational load formatter: picks the little-endian byte lane
// addressed by ea[1:0] and sign/zero extends it, or passes the whole word.
// Ports:
//   readdata_i  32  word returned by the bus
//   ea_lo_i      2  low bits of the effective address (byte lane)
//   opcode_i     6  load opcode (LW, LB, LBU); anything else yields 0
//   result_o    32  formatted load value
module load_byte_extract
  import memory_access_unit_pkg::*;
(
  input  logic [31:0] readdata_i,
  input  logic [1:0]  ea_lo_i,
  input  logic [5:0]  opcode_i,
  output logic [31:0] result_o
);

  logic [7:0] lane [4];
  logic [7:0] sel_byte;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = readdata_i[8*gi +: 8];
  end

  always_comb begin
    sel_byte = lane[ea_lo_i];
    result_o = 32'h0;
    case (opcode_i)
      OPCODE_LW:  result_o = readdata_i;
      OPCODE_LB:  result_o = {{24{sel_byte[7]}}, sel_byte};
      OPCODE_LBU: result_o = {24'h0, sel_byte};
      default:    result_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// memory_access_unit
// Executes one LW/SW/LB/LBU/SB per request as a single Avalon-MM transfer.
// IDLE -> BUS -> DONE for legal requests, IDLE -> DONE for faults.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   start, opcode          request (sampled in IDLE only) and its opcode
//   base, offset           address operands, ea = base + offset
//   store_data             store source register
//   done, load_data, fault one-cycle completion with result / fault flag
//   address, read, write, byteenable, writedata, readdata, waitrequest
//                          Avalon master
module memory_access_unit
  import memory_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  mau_state_e  state_q, state_d;
  logic [31:0] ea_q, ea_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] ld_q, ld_d;
  logic        fault_q, fault_d;

  logic [31:0] ea_calc;
  logic [31:0] extract_result;
  logic        in_bus;

  assign ea_calc = base + offset;

  load_byte_extract u_extract (
    .readdata_i (readdata),
    .ea_lo_i    (ea_q[1:0]),
    .opcode_i   (op_q),
    .result_o   (extract_result)
  );

  always_comb begin
    state_d = state_q;
    ea_d    = ea_q;
    op_d    = op_q;
    sdata_d = sdata_q;
    ld_d    = ld_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ea_d    = ea_calc;
          op_d    = opcode;
          sdata_d = store_data;
          ld_d    = 32'h0;
          fault_d = op_fault(opcode, ea_calc[1:0]);
          state_d = op_fault(opcode, ea_calc[1:0]) ? DONE : BUS;
        end
      end
      BUS: begin
        if (!waitrequest) begin
          state_d = DONE;
          // Stores leave ld_q at the zero written on acceptance.
          if (!op_is_store(op_q)) ld_d = extract_result;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ea_q    <= 32'h0;
      op_q    <= 6'h0;
      sdata_q <= 32'h0;
      ld_q    <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ea_q    <= ea_d;
      op_q    <= op_d;
      sdata_q <= sdata_d;
      ld_q    <= ld_d;
      fault_q <= fault_d;
    end
  end

  // Bus outputs decode straight from the registered state, so they are
  // stable for the whole BUS residency and zero everywhere else.
  assign in_bus     = (state_q == BUS);
  assign address    = in_bus ? {ea_q[31:2], 2'b00} : 32'h0;
  assign read       = in_bus && !op_is_store(op_q);
  assign write      = in_bus && op_is_store(op_q);
  assign byteenable = !in_bus          ? 4'b0000 :
                      op_is_word(op_q) ? 4'b1111 : (4'b0001 << ea_q[1:0]);
  assign writedata  = !write           ? 32'h0 :
                      op_is_word(op_q) ? sdata_q : {4{sdata_q[7:0]}};

  assign done      = (state_q == DONE);
  assign fault     = done && fault_q;
  assign load_data = done ? ld_q : 32'h0;

endmodule
